// File: rtl/in_buf_rd_ctrl.sv
// Credit-based read controller for the input buffer: issues reads while the downstream
// FIFO plus outstanding reads fit in CREDITS, and frames returned words by SOF/length.
module in_buf_rd_ctrl #(
  parameter int CREDITS    = 8,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] frame_words,
  output logic                 buf_rd_en,
  input  logic                 buf_valid,
  input  logic                 buf_sof,
  input  logic                 dn_pop,
  output logic                 word_valid,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 frame_done,
  output logic                 sof_err,
  output logic                 pop_err
);

  localparam int OCC_W = $clog2(CREDITS + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int SUM_W = $clog2(CREDITS + RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, SEEK, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [RD_LATENCY-1:0]  inflight;
  logic [LAT_W-1:0]       inflight_cnt;
  logic [OCC_W-1:0]       occ, occ_nxt;
  logic [CNT_WIDTH-1:0]   frame_len, frame_len_nxt, word_cnt_nxt;
  logic [CNT_WIDTH-1:0]   len_in, cnt_cand, len_cand;
  logic                   frame_done_nxt, sof_err_nxt, pop_ok;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight_cnt = inflight_cnt + LAT_W'(inflight[i]);
  end

  // Reads are throttled from registered state only, so returns and pops this cycle are ignored
  assign buf_rd_en  = (state != IDLE) &&
                      ((SUM_W'(occ) + SUM_W'(inflight_cnt)) < SUM_W'(CREDITS));
  assign word_valid = buf_valid && ((state == ACTIVE) || ((state == SEEK) && buf_sof));

  // A pop from an empty FIFO is flagged but never decrements the count
  assign pop_ok = dn_pop && (occ != '0);

  always_comb begin
    occ_nxt = occ;
    if (word_valid && !pop_ok)
      occ_nxt = occ + OCC_W'(1);
    else if (!word_valid && pop_ok)
      occ_nxt = occ - OCC_W'(1);
  end

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    frame_len_nxt  = frame_len;
    frame_done_nxt = 1'b0;
    sof_err_nxt    = 1'b0;
    len_in         = (frame_words == '0) ? CNT_WIDTH'(1) : frame_words;
    cnt_cand       = buf_sof ? CNT_WIDTH'(1) : (word_cnt + CNT_WIDTH'(1));
    len_cand       = buf_sof ? len_in : frame_len;
    case (state)
      IDLE: state_nxt = SEEK;
      SEEK, ACTIVE: begin
        if (word_valid) begin
          word_cnt_nxt  = cnt_cand;
          frame_len_nxt = len_cand;
          sof_err_nxt   = (state == ACTIVE) && buf_sof && (word_cnt < frame_len);
          if (cnt_cand == len_cand) begin
            frame_done_nxt = 1'b1;
            state_nxt      = SEEK;
          end else begin
            state_nxt = ACTIVE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      inflight   <= '0;
      occ        <= '0;
      word_cnt   <= '0;
      frame_len  <= CNT_WIDTH'(1);
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      pop_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      inflight[0] <= buf_rd_en;
      for (int i = 1; i < RD_LATENCY; i++)
        inflight[i] <= inflight[i-1];
      occ        <= occ_nxt;
      word_cnt   <= word_cnt_nxt;
      frame_len  <= frame_len_nxt;
      frame_done <= frame_done_nxt;
      sof_err    <= sof_err_nxt;
      pop_err    <= dn_pop && (occ == '0);
    end
  end

endmodule

// File: tb/tb_in_buf_rd_ctrl.sv
// Bench for in_buf_rd_ctrl: table vectors, directed corner sequences and a randomized
// run checked against a behavioural model with a latency-accurate buffer stand-in.
module tb_in_buf_rd_ctrl;

  localparam int CREDITS    = 8;
  localparam int RD_LATENCY = 2;
  localparam int CNT_WIDTH  = 16;

  logic                 clk = 1'b0;
  logic                 rst, en, buf_rd_en, buf_valid, buf_sof, dn_pop, word_valid;
  logic [CNT_WIDTH-1:0] frame_words, word_cnt;
  logic                 frame_done, sof_err, pop_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Buffer stand-in: returns one word RD_LATENCY cycles after each read request
  bit rd_hist[$];
  int cyc;

  // Reference model: plain counters plus a queue of issue times for outstanding reads
  bit m_run, m_in_frame, m_done, m_serr, m_perr, exp_rd, exp_wv;
  int m_occ, m_cnt, m_len;
  int issue_q[$];

  typedef struct {
    bit             en;
    logic [15:0]    fw;
    bit             sof;
    bit             pop;
    bit             exp_rd;
    bit             exp_wv;
    logic [15:0]    exp_cnt;
    bit             exp_done;
  } vec_t;

  vec_t vecs[9];

  in_buf_rd_ctrl #(.CREDITS(CREDITS), .RD_LATENCY(RD_LATENCY), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_words(frame_words), .buf_rd_en(buf_rd_en),
    .buf_valid(buf_valid), .buf_sof(buf_sof), .dn_pop(dn_pop), .word_valid(word_valid),
    .word_cnt(word_cnt), .frame_done(frame_done), .sof_err(sof_err), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_run = 0; m_in_frame = 0; m_done = 0; m_serr = 0; m_perr = 0;
    m_occ = 0; m_cnt = 0; m_len = 1;
    issue_q.delete();
    rd_hist.delete();
    cyc = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1; en = 0; frame_words = '0; buf_valid = 0; buf_sof = 0; dn_pop = 0;
    #1;
    checkOutput("rst_rd_en", buf_rd_en, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_sof_err", sof_err, 0);
    checkOutput("rst_pop_err", pop_err, 0);
    checkOutput("rst_word_cnt", word_cnt, 0);
    @(negedge clk);
    rst = 0;
    modelReset();
  endtask

  task automatic applyStimulus(input bit i_en, input logic [15:0] i_fw, input bit i_sof, input bit i_pop);
    int old_occ;
    @(negedge clk);
    en = i_en; frame_words = i_fw; buf_sof = i_sof; dn_pop = i_pop;
    buf_valid = (rd_hist.size() >= RD_LATENCY) ? rd_hist[rd_hist.size() - RD_LATENCY] : 1'b0;
    #1;
    while (issue_q.size() > 0 && issue_q[0] < cyc - RD_LATENCY) void'(issue_q.pop_front());
    exp_rd = m_run && (m_occ + issue_q.size() < CREDITS);
    exp_wv = buf_valid && (m_in_frame || (m_run && i_sof));
    checkOutput("buf_rd_en", buf_rd_en, exp_rd);
    checkOutput("word_valid", word_valid, exp_wv);
    checkOutput("word_cnt", word_cnt, m_cnt);
    checkOutput("frame_done", frame_done, m_done);
    checkOutput("sof_err", sof_err, m_serr);
    checkOutput("pop_err", pop_err, m_perr);
    rd_hist.push_back(buf_rd_en);
    if (rd_hist.size() > RD_LATENCY) void'(rd_hist.pop_front());
    if (exp_rd) issue_q.push_back(cyc);
    m_done = 0; m_serr = 0;
    m_perr = i_pop && (m_occ == 0);
    if (exp_wv) begin
      if (i_sof) begin
        m_serr = m_in_frame;
        m_cnt  = 1;
        m_len  = (i_fw == 0) ? 1 : int'(i_fw);
      end else begin
        m_cnt++;
      end
      if (m_cnt == m_len) begin
        m_done = 1; m_in_frame = 0;
      end else begin
        m_in_frame = 1;
      end
    end
    old_occ = m_occ;
    m_occ = old_occ + int'(exp_wv) - int'(i_pop && old_occ > 0);
    m_run = i_en;
    if (!i_en) m_in_frame = 0;
    cyc++;
  endtask

  initial begin
    int cnt_rd, n_serr, n_done, n_perr;
    rst = 1; en = 0; frame_words = '0; buf_valid = 0; buf_sof = 0; dn_pop = 0;
    modelReset();

    // frame of 4 words with a pop every cycle
    vecs[0] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[2] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[3] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0};
    vecs[4] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0};
    vecs[5] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0};
    vecs[6] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0};
    vecs[7] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 1'b1};
    vecs[8] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 1'b0};

    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].fw, vecs[i].sof, vecs[i].pop);
      checkOutput("tbl_rd_en", buf_rd_en, vecs[i].exp_rd);
      checkOutput("tbl_word_valid", word_valid, vecs[i].exp_wv);
      checkOutput("tbl_word_cnt", word_cnt, vecs[i].exp_cnt);
      checkOutput("tbl_frame_done", frame_done, vecs[i].exp_done);
    end

    // credit exhaustion: no pops, every return accepted
    doReset();
    cnt_rd = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 16'd100, k == 3, 1'b0);
      cnt_rd += int'(buf_rd_en);
    end
    checkOutput("credit_rd_count", cnt_rd, 8);
    checkOutput("credit_occ", dut.occ, 8);
    checkOutput("credit_rd_stopped", buf_rd_en, 0);

    // SEEK drops non-SOF words
    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 16'd10, k == 5, 1'b0);
      if (k == 3 || k == 4) checkOutput("seek_drop_wv", word_valid, 0);
      if (k == 5) checkOutput("seek_sof_wv", word_valid, 1);
      if (k == 6) checkOutput("seek_sof_cnt", word_cnt, 1);
    end

    // early SOF inside a 5-word frame
    doReset();
    n_serr = 0; n_done = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 16'd5, (k == 3) || (k == 5), 1'b0);
      n_serr += int'(sof_err);
      n_done += int'(frame_done);
      if (k == 6) checkOutput("early_sof_cnt", word_cnt, 1);
    end
    checkOutput("early_sof_pulses", n_serr, 1);
    checkOutput("early_sof_no_done", n_done, 0);

    // enable dropped with reads outstanding
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(k < 2, 16'd3, 1'b1, 1'b0);
      if (k == 3) begin
        checkOutput("en_drop_rd", buf_rd_en, 0);
        checkOutput("en_drop_wv", word_valid, 0);
        checkOutput("en_drop_inflight3", dut.inflight_cnt, 2);
      end
      if (k == 4) begin
        checkOutput("en_drop_wv_late", word_valid, 0);
        checkOutput("en_drop_inflight4", dut.inflight_cnt, 1);
      end
      if (k == 5) checkOutput("en_drop_inflight5", dut.inflight_cnt, 0);
    end

    // pop on empty, then pop coinciding with a write at occupancy 3
    doReset();
    n_perr = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, k == 0);
      n_perr += int'(pop_err);
    end
    checkOutput("pop_empty_pulses", n_perr, 1);
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 16'd100, k == 3, k == 6);
      if (k == 6) begin
        checkOutput("pop_wr_occ_before", dut.occ, 3);
        checkOutput("pop_wr_wv", word_valid, 1);
      end
      if (k == 7) begin
        checkOutput("pop_wr_occ_after", dut.occ, 3);
        checkOutput("pop_wr_no_err", pop_err, 0);
      end
    end

    // randomized traffic with a mid-run reset
    doReset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) doReset();
      applyStimulus($urandom_range(15, 0) != 0, 16'($urandom_range(5, 0)),
                    $urandom_range(3, 0) == 0, $urandom_range(4, 0) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/in_buf_rd_ctrl.md
IN_BUF_RD_CTRL -- requirements
Module: in_buf_rd_ctrl

Interface
REQ-001 Parameter CREDITS, default 8: downstream FIFO capacity in words; range 2..64.
REQ-002 Parameter RD_LATENCY, default 2: cycles from buf_rd_en assertion to the matching buf_valid.
REQ-003 Parameter CNT_WIDTH, default 16: width of the frame word counter.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  level enable; low forces IDLE.
REQ-007 frame_words  input  CNT_WIDTH  words per frame; sampled on each accepted SOF word.
REQ-008 buf_rd_en  output  1  read request to the input buffer.
REQ-009 buf_valid  input  1  returned word valid, from the buffer.
REQ-010 buf_sof  input  1  returned word is start of frame; qualified by buf_valid.
REQ-011 dn_pop  input  1  downstream FIFO consumed one word.
REQ-012 word_valid  output  1  returned word belongs to a frame; write strobe of the downstream FIFO.
REQ-013 word_cnt  output  CNT_WIDTH  index of the last accepted word in the current frame, 1-based.
REQ-014 frame_done  output  1  one-cycle pulse when the last word of a frame is accepted.
REQ-015 sof_err  output  1  one-cycle pulse on an early SOF.
REQ-016 pop_err  output  1  one-cycle pulse on dn_pop while occupancy is 0.

Function
REQ-017 The block SHALL implement states IDLE, SEEK and ACTIVE.
REQ-018 In any state, en=0 SHALL force IDLE on the next edge.
REQ-019 IDLE with en=1 SHALL go to SEEK on the next edge.
REQ-020 inflight SHALL be a RD_LATENCY-deep shift register of buf_rd_en, and inflight_cnt SHALL be its popcount.
REQ-021 occ SHALL be 0..CREDITS: +1 on word_valid, -1 on dn_pop, unchanged when both occur in the same cycle.
REQ-022 buf_rd_en SHALL be combinational: (state != IDLE) and (occ + inflight_cnt < CREDITS).
REQ-023 Only registered state SHALL feed buf_rd_en; it SHALL not depend on same-cycle dn_pop or buf_valid.
REQ-024 word_valid SHALL be buf_valid & ((state==ACTIVE) | (state==SEEK & buf_sof)), with no added latency.
REQ-025 In SEEK, words without SOF SHALL be dropped, with word_valid=0 and no counter change.
REQ-026 In SEEK, a buf_valid&buf_sof word SHALL set word_cnt=1, latch frame_words into frame_len, and move to ACTIVE.
REQ-027 A latched frame_words value of 0 SHALL be treated as 1.
REQ-028 In ACTIVE, a buf_valid word without SOF SHALL increment word_cnt.
REQ-029 In ACTIVE, buf_valid&buf_sof with word_cnt < frame_len SHALL pulse sof_err, set word_cnt=1, re-latch frame_len and stay in ACTIVE.
REQ-030 When the accepted word brings word_cnt to frame_len, frame_done SHALL pulse on the next edge and the state SHALL go to SEEK.
REQ-031 A single-word frame SHALL go SEEK -> SEEK with a frame_done pulse.
REQ-032 Words returning in IDLE SHALL be dropped, while inflight still retires them.
REQ-033 dn_pop with occ=0 SHALL pulse pop_err and leave occ at 0.
REQ-034 frame_done, sof_err and pop_err SHALL be registered, one cycle after the causing word.

Reset
REQ-035 Asserting rst SHALL clear state to IDLE, occ, inflight and word_cnt to 0, and frame_len to 1.
REQ-036 During reset, buf_rd_en, frame_done, sof_err and pop_err SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL discard all in-flight accounting, and the block SHALL restart in IDLE after release.

Verification
REQ-038 Reset, en=1, buffer always returns data, no dn_pop -> exactly 8 buf_rd_en cycles, then buf_rd_en=0 with occ=8.
REQ-039 frame_words=4, stream SOF+3 words, dn_pop every cycle -> word_cnt 1,2,3,4; frame_done pulses once; state returns to SEEK.
REQ-040 Two non-SOF words then SOF in SEEK -> first two have word_valid=0; SOF word has word_valid=1 and word_cnt=1.
REQ-041 frame_words=5, SOF at word 3 -> sof_err pulses once, word_cnt=1, no frame_done.
REQ-042 en dropped with 2 reads in flight -> buf_rd_en=0 next cycle; late returns give word_valid=0; inflight_cnt reaches 0 after 2 cycles.
REQ-043 dn_pop with occ=0; separately, word_valid and dn_pop together at occ=3 -> pop_err pulses once; occ stays 3.
